// File: rtl/pwm_peripheral.sv
// Shared 8-bit PWM driving 16 output pins from SPI-written enable/duty registers.
// Duty is double-buffered and only takes effect at PWM period boundaries.
module pwm_peripheral #(
  parameter int unsigned CLK_DIV = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        pwm_sync
);

  localparam logic [15:0] DivMax = 16'(CLK_DIV - 1);

  logic [15:0] prescaler_q, prescaler_d;
  logic [7:0]  pwm_cnt_q, pwm_cnt_d;
  logic [7:0]  duty_shadow_q, duty_shadow_d;
  logic [15:0] out_q, out_d;
  logic        pwm_sync_q, pwm_sync_d;

  logic        tick;
  logic        wrap;
  logic        pwm_level;
  logic [15:0] en_out;
  logic [15:0] en_pwm;

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  always_comb begin
    tick          = (prescaler_q == DivMax);
    wrap          = tick && (pwm_cnt_q == 8'hFF);
    prescaler_d   = tick ? 16'd0 : prescaler_q + 16'd1;
    pwm_cnt_d     = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
    // New duty is latched on the same edge the counter wraps to 0.
    duty_shadow_d = wrap ? pwm_duty_cycle : duty_shadow_q;
    pwm_level     = (duty_shadow_q == 8'hFF) || (pwm_cnt_q < duty_shadow_q);
    out_d         = en_out & (~en_pwm | {16{pwm_level}});
    pwm_sync_d    = wrap;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler_q   <= '0;
      pwm_cnt_q     <= '0;
      duty_shadow_q <= '0;
      out_q         <= '0;
      pwm_sync_q    <= 1'b0;
    end else begin
      prescaler_q   <= prescaler_d;
      pwm_cnt_q     <= pwm_cnt_d;
      duty_shadow_q <= duty_shadow_d;
      out_q         <= out_d;
      pwm_sync_q    <= pwm_sync_d;
    end
  end

  assign out      = out_q;
  assign pwm_sync = pwm_sync_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Bench for pwm_peripheral: cycle-count reference model plus directed period measurements.
module tb_pwm_peripheral;

  localparam int CLK_DIV = 13;
  localparam int PERIOD  = 256 * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  en_reg_out_7_0  = 8'h00;
  logic [7:0]  en_reg_out_15_8 = 8'h00;
  logic [7:0]  en_reg_pwm_7_0  = 8'h00;
  logic [7:0]  en_reg_pwm_15_8 = 8'h00;
  logic [7:0]  pwm_duty_cycle  = 8'h00;
  logic [15:0] out;
  logic        pwm_sync;

  int checks = 0;
  int errors = 0;
  int shown  = 0;

  pwm_peripheral #(.CLK_DIV(CLK_DIV)) dut (
    .clk             (clk),
    .rst             (rst),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .out             (out),
    .pwm_sync        (pwm_sync)
  );

  always #5 clk = ~clk;

  // Reference model: position in the period follows from clocks elapsed since reset.
  int unsigned t;
  int unsigned cnt;
  logic [7:0]  shadow;
  logic        level;
  logic [15:0] exp_out;
  logic        exp_sync;
  bit          model_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      t        = 0;
      shadow   = 8'h00;
      exp_out  = 16'h0000;
      exp_sync = 1'b0;
      model_valid = 1'b1;
    end else begin
      cnt      = (t / CLK_DIV) % 256;
      level    = (shadow == 8'd255) || (cnt < int'(shadow));
      exp_out  = 16'h0000;
      for (int i = 0; i < 16; i++) begin
        logic e, p;
        e = (i < 8) ? en_reg_out_7_0[i] : en_reg_out_15_8[i-8];
        p = (i < 8) ? en_reg_pwm_7_0[i] : en_reg_pwm_15_8[i-8];
        exp_out[i] = e ? (p ? level : 1'b1) : 1'b0;
      end
      exp_sync = ((t + 1) % PERIOD) == 0;
      if (exp_sync) shadow = pwm_duty_cycle;
      t++;
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      checks++;
      if (out !== exp_out) begin
        errors++;
        if (shown < 20) $display("FAIL model_out t=%0t got %h exp %h", $time, out, exp_out);
        shown++;
      end
      checks++;
      if (pwm_sync !== exp_sync) begin
        errors++;
        if (shown < 20) $display("FAIL model_sync t=%0t got %0b exp %0b", $time, pwm_sync, exp_sync);
        shown++;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", name, act, exp);
    end
  endtask

  task automatic set_en(input logic [15:0] e, input logic [15:0] p);
    {en_reg_out_15_8, en_reg_out_7_0} = e;
    {en_reg_pwm_15_8, en_reg_pwm_7_0} = p;
  endtask

  // Returns number of negedges until pwm_sync is seen (0 if the bound expires).
  task automatic wait_sync(output int n);
    n = 0;
    for (int k = 1; k <= 2 * PERIOD; k++) begin
      @(negedge clk);
      if (pwm_sync === 1'b1) begin
        n = k;
        break;
      end
    end
    if (n == 0) chk("sync_timeout", 0, 1);
  endtask

  // Called at a sync negedge; counts out[0] high over the following period.
  task automatic measure(input int chg_at, input logic [7:0] chg_val, output int hi);
    hi = 0;
    for (int i = 0; i < PERIOD; i++) begin
      @(negedge clk);
      if (i == chg_at) pwm_duty_cycle = chg_val;
      if (out[0] === 1'b1) hi++;
    end
  endtask

  int n, hi, bad;

  initial begin
    // Reset with nonzero inputs.
    set_en(16'hFFFF, 16'h0000);
    pwm_duty_cycle = 8'd77;
    repeat (3) @(negedge clk);
    chk("reset_out", int'(out), 0);
    chk("reset_sync", int'(pwm_sync), 0);
    rst = 1'b0;
    wait_sync(n);
    chk("first_sync_clk", n, 3328);

    // Static mode.
    set_en(16'h00FF, 16'h0000);
    @(negedge clk);
    chk("static_00ff", int'(out), 16'h00FF);
    repeat (40) @(negedge clk);
    chk("static_hold", int'(out), 16'h00FF);
    set_en(16'h0000, 16'hFFFF);
    @(negedge clk);
    chk("pwm_no_enable", int'(out), 0);

    // 50% duty.
    set_en(16'h0001, 16'h0001);
    pwm_duty_cycle = 8'd128;
    wait_sync(n);
    measure(-1, 8'd0, hi);  chk("duty128_p1", hi, 1664);
    measure(-1, 8'd0, hi);  chk("duty128_p2", hi, 1664);
    chk("sync_at_boundary", int'(pwm_sync), 1);
    chk("upper_bits_low", int'(out[15:1]), 0);

    // Extremes.
    pwm_duty_cycle = 8'd0;
    measure(-1, 8'd0, hi);  chk("duty128_p3", hi, 1664);
    measure(-1, 8'd0, hi);  chk("duty0", hi, 0);
    pwm_duty_cycle = 8'd255;
    measure(-1, 8'd0, hi);  chk("duty0_before_255", hi, 0);
    measure(-1, 8'd0, hi);  chk("duty255", hi, PERIOD);
    pwm_duty_cycle = 8'd1;
    measure(-1, 8'd0, hi);  chk("duty255_before_1", hi, PERIOD);
    measure(-1, 8'd0, hi);  chk("duty1", hi, 13);

    // Buffered update mid-period.
    pwm_duty_cycle = 8'd64;
    measure(-1, 8'd0, hi);    chk("duty1_before_64", hi, 13);
    measure(1300, 8'd192, hi); chk("duty64_buffered", hi, 832);
    measure(-1, 8'd0, hi);    chk("duty192", hi, 2496);

    // Mid-period reset at cnt ~50 with out[0] high.
    repeat (50 * CLK_DIV + 5) @(negedge clk);
    chk("pre_reset_high", int'(out[0]), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midreset_out", int'(out), 0);
    bad = 0;
    n = 0;
    for (int k = 1; k <= 2 * PERIOD; k++) begin
      @(negedge clk);
      if (pwm_sync === 1'b1) begin
        n = k;
        break;
      end
      if (out[0] !== 1'b0) bad++;
    end
    chk("midreset_low_until_sync", bad, 0);
    chk("midreset_sync_clk", n, 3328);

    // Randomized enables, duty and occasional reset.
    for (int i = 0; i < 3 * PERIOD; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 3999) == 0);
      if ($urandom_range(0, 99) == 0) set_en(16'($urandom), 16'($urandom));
      if ($urandom_range(0, 499) == 0) pwm_duty_cycle = 8'($urandom);
    end
    rst = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
